// File: rtl/disc_reader_pkg.sv
// Shared constants, types and the byte-packing helper for the disc flux timer.
// Build option: DISC_READER_INDEX_EN enables the index-pulse path in disc_reader.
package disc_reader_pkg;

  localparam int              TIMER_W        = 7;
  localparam logic [TIMER_W-1:0] TIMER_CARRY_AT = 7'd126;
  localparam logic [7:0]      CARRY_BYTE     = 8'h7F;
  localparam int              INDEX_FLAG_BIT = 7;

  // Which kind of byte (if any) is stored in the current cycle.
  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_INDEX = 2'd1,
    SEL_DATA  = 2'd2,
    SEL_CARRY = 2'd3
  } store_sel_e;

  // Timing byte: bit 7 flags an index event, bits 6:0 carry the timer value.
  function automatic logic [7:0] make_byte(input logic index_flag,
                                           input logic [TIMER_W-1:0] count);
    logic [7:0] b;
    b = {1'b0, count};
    b[INDEX_FLAG_BIT] = index_flag;
    return b;
  endfunction

endpackage

// File: rtl/disc_reader_edge_sync.sv
// Multi-stage synchroniser for an asynchronous drive line followed by a
// rising-edge detector: a high level of any length yields a single-cycle pulse.
module disc_reader_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  // Stage 0 is the metastability-catching flop; the last stage is safe to use.
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;

  // Shift the raw line through the synchroniser and keep one extra delayed copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      prev_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw};
      prev_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  // ---- stage boundary: synchronised level -> edge pulse ----
  assign pulse = sync_p0[SYNC_STAGES-1] & ~prev_p1;

endmodule

// File: rtl/disc_reader.sv
// Flux-transition timer: counts clocks between read-data (and optionally
// index) pulses and writes one timing byte per event into a downstream FIFO.
// Long intervals are split into 0x7F carry bytes.
// Build option: define DISC_READER_INDEX_EN to enable the index path; when it
// is undefined FD_INDEX_IN is ignored and DATA[7] is always 0.
module disc_reader
  import disc_reader_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       CLKEN,
  input  logic       RUN,
  input  logic       FD_RDDATA_IN,
  input  logic       FD_INDEX_IN,
  output logic [7:0] DATA,
  output logic       WRITE
);

  logic               dat_pulse;
  logic               idx_pulse;

  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_nxt;
  logic               idx_pend;
  logic               idx_pend_nxt;
  logic               dat_pend;
  logic               dat_pend_nxt;
  logic               idx_ev;
  logic               dat_ev;
  store_sel_e         sel;
  logic [7:0]         byte_nxt;

  logic [7:0]         data_p1;
  logic               vld_p1;

  // ---- stage boundary: asynchronous drive lines -> edge pulses ----
  disc_reader_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rddata_sync (
    .clk  (CLOCK),
    .rst_n(RESET),
    .raw  (FD_RDDATA_IN),
    .pulse(dat_pulse)
  );

`ifdef DISC_READER_INDEX_EN
  disc_reader_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_index_sync (
    .clk  (CLOCK),
    .rst_n(RESET),
    .raw  (FD_INDEX_IN),
    .pulse(idx_pulse)
  );
`else
  // Index line deliberately left unconnected in this build.
  logic unused_index;
  assign unused_index = FD_INDEX_IN;
  assign idx_pulse    = 1'b0;
`endif

  // Carry fires once the timer reaches the last value a 7-bit byte can hold
  // without colliding with the 0x7F carry code.
  function automatic logic timer_at_carry(input logic [TIMER_W-1:0] t);
    return (t == TIMER_CARRY_AT);
  endfunction

  // Events seen this cycle include any left pending from frozen or shared cycles.
  assign idx_ev = idx_pulse | idx_pend;
  assign dat_ev = dat_pulse | dat_pend;

  // Priority mux: index, then data, then carry, else count; also pending-flag upkeep.
  always_comb begin
    sel          = SEL_NONE;
    timer_nxt    = timer;
    idx_pend_nxt = idx_pend;
    dat_pend_nxt = dat_pend;
    if (!RUN) begin
      timer_nxt    = '0;
      idx_pend_nxt = 1'b0;
      dat_pend_nxt = 1'b0;
    end else if (!CLKEN) begin
      // Timebase paused: remember edges so none are lost.
      idx_pend_nxt = idx_ev;
      dat_pend_nxt = dat_ev;
    end else if (idx_ev) begin
      sel          = SEL_INDEX;
      timer_nxt    = '0;
      idx_pend_nxt = 1'b0;
      // A coincident data edge is stored as 0x00 in the next enabled cycle.
      dat_pend_nxt = dat_ev;
    end else if (dat_ev) begin
      sel          = SEL_DATA;
      timer_nxt    = '0;
      idx_pend_nxt = 1'b0;
      dat_pend_nxt = 1'b0;
    end else if (timer_at_carry(timer)) begin
      sel          = SEL_CARRY;
      timer_nxt    = '0;
    end else begin
      timer_nxt    = timer + 7'd1;
    end
  end

  // Byte formatting for the selected store.
  always_comb begin
    byte_nxt = 8'h00;
    case (sel)
      SEL_INDEX: byte_nxt = make_byte(1'b1, timer);
      SEL_DATA:  byte_nxt = make_byte(1'b0, timer);
      SEL_CARRY: byte_nxt = CARRY_BYTE;
      default:   byte_nxt = 8'h00;
    endcase
  end

  // Timer and pending-flag state.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      timer    <= '0;
      idx_pend <= 1'b0;
      dat_pend <= 1'b0;
    end else begin
      timer    <= timer_nxt;
      idx_pend <= idx_pend_nxt;
      dat_pend <= dat_pend_nxt;
    end
  end

  // ---- stage boundary: registered FIFO write port ----
  // DATA only changes on a store; WRITE is a one-cycle strobe.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      data_p1 <= 8'h00;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= (sel != SEL_NONE);
      if (sel != SEL_NONE) begin
        data_p1 <= byte_nxt;
      end
    end
  end

  assign DATA  = data_p1;
  assign WRITE = vld_p1;

endmodule

// File: tb/tb_disc_reader.sv
// Self-checking bench for disc_reader: a per-cycle behavioural reference
// (input history delay line plus the timing-byte rules) checks every strobe,
// and directed scenarios check byte streams against hand-derived values.
module tb_disc_reader;

  localparam int SYNC = 2;

  logic       CLOCK;
  logic       RESET;
  logic       CLKEN;
  logic       RUN;
  logic       FD_RDDATA_IN;
  logic       FD_INDEX_IN;
  logic [7:0] DATA;
  logic       WRITE;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model state
  bit         h_d [0:SYNC+1];
  bit         h_i [0:SYNC+1];
  int         m_c;
  bit         m_pi;
  bit         m_pd;
  bit         m_wr;
  logic [7:0] m_data;

  logic [7:0] log_q[$];

  disc_reader #(.SYNC_STAGES(SYNC)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .CLKEN       (CLKEN),
    .RUN         (RUN),
    .FD_RDDATA_IN(FD_RDDATA_IN),
    .FD_INDEX_IN (FD_INDEX_IN),
    .DATA        (DATA),
    .WRITE       (WRITE)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behavioural reference evaluated at each rising edge from the inputs
  // present at that edge.
  task automatic model_step();
    bit de;
    bit ie;
    if (!RESET) begin
      for (int j = 0; j <= SYNC + 1; j++) begin
        h_d[j] = 1'b0;
        h_i[j] = 1'b0;
      end
      m_c = 0; m_pi = 0; m_pd = 0; m_wr = 0; m_data = 8'h00;
      return;
    end
    for (int j = SYNC + 1; j > 0; j--) begin
      h_d[j] = h_d[j-1];
      h_i[j] = h_i[j-1];
    end
    h_d[0] = FD_RDDATA_IN;
    h_i[0] = FD_INDEX_IN;
    de = (h_d[SYNC] && !h_d[SYNC+1]) || m_pd;
`ifdef DISC_READER_INDEX_EN
    ie = (h_i[SYNC] && !h_i[SYNC+1]) || m_pi;
`else
    ie = 1'b0;
`endif
    m_wr = 1'b0;
    if (!RUN) begin
      m_c = 0; m_pi = 0; m_pd = 0;
    end else if (!CLKEN) begin
      m_pi = ie; m_pd = de;
    end else if (ie) begin
      m_wr = 1'b1; m_data = 8'(128 + m_c); m_c = 0; m_pi = 0; m_pd = de;
    end else if (de) begin
      m_wr = 1'b1; m_data = 8'(m_c); m_c = 0; m_pi = 0; m_pd = 0;
    end else if (m_c == 126) begin
      m_wr = 1'b1; m_data = 8'h7F; m_c = 0;
    end else begin
      m_c = m_c + 1;
    end
  endtask

  // One clock: model at the edge, compare 1 ns later, return at the falling edge.
  task automatic tick();
    @(posedge CLOCK);
    model_step();
    cyc++;
    #1;
    n_cmp++;
    assert (WRITE === m_wr) else begin
      n_err++;
      $error("FAIL write_strobe cyc=%0d observed=%0b expected=%0b", cyc, WRITE, m_wr);
    end
    if (m_wr) begin
      n_cmp++;
      assert (DATA === m_data) else begin
        n_err++;
        $error("FAIL data_byte cyc=%0d observed=%02h expected=%02h", cyc, DATA, m_data);
      end
    end
    if (WRITE === 1'b1) log_q.push_back(DATA);
    @(negedge CLOCK);
  endtask

  task automatic flush();
    RUN = 1'b0; CLKEN = 1'b1; FD_RDDATA_IN = 1'b0; FD_INDEX_IN = 1'b0;
    repeat (SYNC + 3) tick();
    log_q.delete();
  endtask

  // Data pulse, i low clocks, second pulse; bytes after the first must sum to i.
  task automatic interval_test(input int i);
    int sum;
    int mx;
    flush();
    RUN = 1'b1;
    FD_RDDATA_IN = 1'b1; tick();
    FD_RDDATA_IN = 1'b0; repeat (i) tick();
    FD_RDDATA_IN = 1'b1; tick();
    FD_RDDATA_IN = 1'b0; repeat (SYNC + 2) tick();
    sum = 0; mx = 0;
    for (int k = 0; k < log_q.size(); k++) begin
      if (k > 0) sum += int'(log_q[k]);
      if (int'(log_q[k]) > mx) mx = int'(log_q[k]);
    end
    chk($sformatf("sweep_sum_i%0d", i), sum, i);
    chk($sformatf("sweep_max_ok_i%0d", i), int'(mx <= 127), 1);
  endtask

  initial begin
    RESET = 1'b0; CLKEN = 1'b0; RUN = 1'b0;
    FD_RDDATA_IN = 1'b0; FD_INDEX_IN = 1'b0;

    // 1. reset state, then first pulse after release
    repeat (10) tick();
    chk("reset_data", int'(DATA), 0);
    chk("reset_write", int'(WRITE), 0);
    RESET = 1'b1; RUN = 1'b1; CLKEN = 1'b1; FD_RDDATA_IN = 1'b1;
    log_q.delete();
    tick();
    FD_RDDATA_IN = 1'b0;
    repeat (4) tick();
    chk("first_pulse_count", log_q.size(), 1);
    if (log_q.size() > 0) chk("first_pulse_small", int'(log_q[0] <= 8'h03), 1);

    // 2. interval sweep: every short interval plus random long ones
    for (int i = 1; i <= 140; i++) interval_test(i);
    for (int r = 0; r < 30; r++) interval_test(int'($urandom_range(141, 511)));

    // 3. 128-clock spacing splits into carry then zero
    flush();
    RUN = 1'b1;
    FD_RDDATA_IN = 1'b1; tick();
    FD_RDDATA_IN = 1'b0; repeat (127) tick();
    FD_RDDATA_IN = 1'b1; tick();
    FD_RDDATA_IN = 1'b0; repeat (SYNC + 4) tick();
    chk("carry_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("carry_byte", int'(log_q[1]), 8'h7F);
      chk("carry_tail", int'(log_q[2]), 8'h00);
    end

`ifdef DISC_READER_INDEX_EN
    // 4. carry followed by index event
    flush();
    RUN = 1'b1;
    FD_RDDATA_IN = 1'b1; tick();
    FD_RDDATA_IN = 1'b0; repeat (127) tick();
    FD_INDEX_IN = 1'b1; tick();
    FD_INDEX_IN = 1'b0; repeat (SYNC + 4) tick();
    chk("idx_carry_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("idx_carry_byte", int'(log_q[1]), 8'h7F);
      chk("idx_tail_byte", int'(log_q[2]), 8'h80);
    end

    // 5a. simultaneous index and data rise after 10 clocks
    flush();
    RUN = 1'b1;
    FD_RDDATA_IN = 1'b1; tick();
    FD_RDDATA_IN = 1'b0; repeat (10) tick();
    FD_RDDATA_IN = 1'b1; FD_INDEX_IN = 1'b1; tick();
    FD_RDDATA_IN = 1'b0; FD_INDEX_IN = 1'b0; repeat (SYNC + 4) tick();
    chk("coincident_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("coincident_index", int'(log_q[1]), 8'h8A);
      chk("coincident_data", int'(log_q[2]), 8'h00);
    end
`endif

    // 5b. a long data pulse is one event
    flush();
    RUN = 1'b1;
    FD_RDDATA_IN = 1'b1; repeat (20) tick();
    FD_RDDATA_IN = 1'b0; repeat (SYNC + 4) tick();
    chk("long_pulse_count", log_q.size(), 1);

    // 6a. frozen timebase excluded from the stored interval
    flush();
    RUN = 1'b1;
    FD_RDDATA_IN = 1'b1; tick();
    FD_RDDATA_IN = 1'b0; repeat (20) tick();
    CLKEN = 1'b0; repeat (50) tick();
    CLKEN = 1'b1; repeat (30) tick();
    FD_RDDATA_IN = 1'b1; tick();
    FD_RDDATA_IN = 1'b0; repeat (SYNC + 4) tick();
    chk("clken_count", log_q.size(), 2);
    if (log_q.size() == 2) chk("clken_value", int'(log_q[1]), 50);

    // 6b. RUN low: pulses never produce writes
    flush();
    for (int p = 0; p < 8; p++) begin
      FD_RDDATA_IN = 1'b1; FD_INDEX_IN = 1'b1; tick();
      FD_RDDATA_IN = 1'b0; FD_INDEX_IN = 1'b0; repeat (4) tick();
    end
    chk("run_low_writes", log_q.size(), 0);

    // reset mid-operation aborts an in-flight store
    flush();
    RUN = 1'b1;
    repeat (5) tick();
    FD_RDDATA_IN = 1'b1; tick();
    FD_RDDATA_IN = 1'b0; tick();
    RESET = 1'b0;
    #1;
    chk("midreset_write", int'(WRITE), 0);
    chk("midreset_data", int'(DATA), 0);
    @(negedge CLOCK);
    tick();
    RESET = 1'b1;
    repeat (6) tick();
    chk("midreset_aborted", log_q.size(), 0);

    // randomized traffic against the reference model
    RUN = 1'b1; CLKEN = 1'b1;
    for (int t = 0; t < 4000; t++) begin
      RUN          = ($urandom_range(0, 99) < 97);
      CLKEN        = ($urandom_range(0, 99) < 80);
      FD_RDDATA_IN = ($urandom_range(0, 99) < 15);
      FD_INDEX_IN  = ($urandom_range(0, 99) < 4);
      RESET        = ($urandom_range(0, 999) != 0);
      tick();
    end
    RESET = 1'b1; RUN = 1'b0; FD_RDDATA_IN = 1'b0; FD_INDEX_IN = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
